// File: rtl/decode.sv
// ---------------------------------------------------------------------------
// decode -- RV32I decode stage.
//
// Pulls the register addresses out of the fetched instruction combinationally.
// The regfile returns operand data in the same cycle, and on capture the
// decoded fields and operands are registered for execute.
//
// A load in decode followed by a dependent instruction gives a load-use
// hazard. Decode then stalls fetch and inserts exactly one bubble.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   instr, PC         instruction and its address from fetch
//   pipeline_valid    instr/PC valid this cycle
//   stall             hold request to fetch (combinational)
//   flush             redirect from execute, kills decode contents
//   exe_stall         execute cannot accept this cycle
//   rs1/rs2_addr      regfile read addresses (combinational)
//   rs1/rs2_data      regfile read data (combinational)
//   dec_*             registered decode results for execute
// ---------------------------------------------------------------------------
module decode #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic [ADDR_W-1:0] PC,
  input  logic              pipeline_valid,
  output logic              stall,
  input  logic              flush,
  input  logic              exe_stall,
  output logic [4:0]        rs1_addr,
  output logic [4:0]        rs2_addr,
  input  logic [31:0]       rs1_data,
  input  logic [31:0]       rs2_data,
  output logic              dec_valid,
  output logic [ADDR_W-1:0] dec_PC,
  output logic [6:0]        dec_opcode,
  output logic [2:0]        dec_funct3,
  output logic              dec_funct7_b5,
  output logic [4:0]        dec_rd,
  output logic              dec_rd_wr_en,
  output logic              dec_is_load,
  output logic [31:0]       dec_imm,
  output logic [31:0]       dec_op1,
  output logic [31:0]       dec_op2,
  output logic              dec_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [4:0]  rd;
    logic        rd_wr_en;
    logic        is_load;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  logic [31:0] iw;
  dec_t        d;
  logic        uses_rs1, uses_rs2, hazard;

  assign iw       = instr[31:0];
  assign rs1_addr = iw[19:15];
  assign rs2_addr = iw[24:20];

  // Every legal opcode ends in 2'b11, so the 7-bit match rejects a bad
  // instr[1:0] without a separate check.
  always_comb begin
    d           = '0;
    d.opcode    = iw[6:0];
    d.funct3    = iw[14:12];
    d.funct7_b5 = iw[30];
    d.rd        = iw[11:7];
    uses_rs1    = 1'b1;
    uses_rs2    = 1'b0;
    case (iw[6:0])
      OP_LUI, OP_AUIPC: begin
        d.imm    = {iw[31:12], 12'b0};
        d.rd_wr_en = 1'b1;
        uses_rs1 = 1'b0;
      end
      OP_JAL: begin
        d.imm    = {{11{iw[31]}}, iw[31], iw[19:12], iw[20], iw[30:21], 1'b0};
        d.rd_wr_en = 1'b1;
        uses_rs1 = 1'b0;
      end
      OP_JALR, OP_OPIMM: begin
        d.imm    = {{20{iw[31]}}, iw[31:20]};
        d.rd_wr_en = 1'b1;
      end
      OP_LOAD: begin
        d.imm    = {{20{iw[31]}}, iw[31:20]};
        d.rd_wr_en = 1'b1;
        d.is_load  = 1'b1;
      end
      OP_BRANCH: begin
        d.imm    = {{19{iw[31]}}, iw[31], iw[7], iw[30:25], iw[11:8], 1'b0};
        uses_rs2 = 1'b1;
      end
      OP_STORE: begin
        d.imm    = {{20{iw[31]}}, iw[31:25], iw[11:7]};
        uses_rs2 = 1'b1;
      end
      OP_OP: begin
        d.rd_wr_en = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    // x0 writes are dropped here so execute/writeback never see them
    if (iw[11:7] == 5'd0) d.rd_wr_en = 1'b0;
  end

  // Load-use: the load still in decode has not produced its data yet.
  assign hazard = pipeline_valid & dec_valid & dec_is_load & (dec_rd != 5'd0) &
                  (((dec_rd == rs1_addr) & uses_rs1) | ((dec_rd == rs2_addr) & uses_rs2));

  assign stall = ~flush & (exe_stall | hazard);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_valid     <= 1'b0;
      dec_PC        <= '0;
      dec_opcode    <= '0;
      dec_funct3    <= '0;
      dec_funct7_b5 <= 1'b0;
      dec_rd        <= '0;
      dec_rd_wr_en  <= 1'b0;
      dec_is_load   <= 1'b0;
      dec_imm       <= '0;
      dec_op1       <= '0;
      dec_op2       <= '0;
      dec_illegal   <= 1'b0;
    end else if (flush) begin
      dec_valid <= 1'b0;
    end else if (!exe_stall) begin
      if (hazard || !pipeline_valid) begin
        // bubble: only the valid bit drops, payload is left as-is
        dec_valid <= 1'b0;
      end else begin
        dec_valid     <= 1'b1;
        dec_PC        <= PC;
        dec_opcode    <= d.opcode;
        dec_funct3    <= d.funct3;
        dec_funct7_b5 <= d.funct7_b5;
        dec_rd        <= d.rd;
        dec_rd_wr_en  <= d.rd_wr_en;
        dec_is_load   <= d.is_load;
        dec_imm       <= d.imm;
        dec_op1       <= rs1_data;
        dec_op2       <= rs2_data;
        dec_illegal   <= d.illegal;
      end
    end
  end

endmodule

// File: tb/tb_decode.sv
// ---------------------------------------------------------------------------
// tb_decode -- self-checking bench for decode.
//
// Directed cases come first, then randomized traffic from a small fetch model
// that holds its instruction while stalled. A behavioural model of the stage
// predicts every output.
// ---------------------------------------------------------------------------
module tb_decode;

  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;
  localparam logic [6:0] BR  = 7'h63, LD    = 7'h03, ST  = 7'h23;
  localparam logic [6:0] OPI = 7'h13, OP    = 7'h33;

  logic        clk, reset;
  logic [31:0] instr, PC;
  logic        pipeline_valid, stall, flush, exe_stall;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        dec_valid, dec_funct7_b5, dec_rd_wr_en, dec_is_load, dec_illegal;
  logic [31:0] dec_PC, dec_imm, dec_op1, dec_op2;
  logic [6:0]  dec_opcode;
  logic [2:0]  dec_funct3;
  logic [4:0]  dec_rd;

  logic [31:0] regs [32];
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];

  decode #(.ADDR_W(32), .INSTR_W(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .PC(PC),
    .pipeline_valid(pipeline_valid), .stall(stall), .flush(flush),
    .exe_stall(exe_stall), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .dec_valid(dec_valid),
    .dec_PC(dec_PC), .dec_opcode(dec_opcode), .dec_funct3(dec_funct3),
    .dec_funct7_b5(dec_funct7_b5), .dec_rd(dec_rd), .dec_rd_wr_en(dec_rd_wr_en),
    .dec_is_load(dec_is_load), .dec_imm(dec_imm), .dec_op1(dec_op1),
    .dec_op2(dec_op2), .dec_illegal(dec_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic        wr;
    logic        ld;
    logic [31:0] imm;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        ill;
  } mstate_t;

  mstate_t m;

  task automatic m_clear();
    m = '{v:0, pc:0, opc:0, f3:0, f7:0, rd:0, wr:0, ld:0, imm:0, op1:0, op2:0, ill:0};
  endtask

  // Immediate built arithmetically from the field weights of each format.
  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    int s, sg, r;
    s  = i;
    sg = (s < 0) ? -1 : 0;
    case (i[6:0])
      LD, OPI, JALR: r = s >>> 20;
      ST:            r = (s >>> 25) * 32 + int'(i[11:7]);
      BR:            r = sg * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      LUI, AUIPC:    r = s & 32'hFFFFF000;
      JAL:           r = sg * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      default:       r = 0;
    endcase
    return r;
  endfunction

  function automatic mstate_t cap(input logic [31:0] i, input logic [31:0] p);
    mstate_t c;
    c.v   = 1'b1;
    c.pc  = p;
    c.opc = i[6:0];
    c.f3  = i[14:12];
    c.f7  = i[30];
    c.rd  = i[11:7];
    c.ill = !(i[6:0] inside {LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OP});
    c.ld  = (i[6:0] == LD);
    c.wr  = (i[6:0] inside {LUI, AUIPC, JAL, JALR, LD, OPI, OP}) && (i[11:7] != 0);
    c.imm = ref_imm(i);
    c.op1 = regs[i[19:15]];
    c.op2 = regs[i[24:20]];
    return c;
  endfunction

  task automatic cmp_outputs();
    chk("dec_valid", dec_valid, m.v);
    if (m.v) begin
      chk("dec_PC", dec_PC, m.pc);
      chk("dec_opcode", dec_opcode, m.opc);
      chk("dec_funct3", dec_funct3, m.f3);
      chk("dec_funct7_b5", dec_funct7_b5, m.f7);
      chk("dec_rd", dec_rd, m.rd);
      chk("dec_rd_wr_en", dec_rd_wr_en, m.wr);
      chk("dec_is_load", dec_is_load, m.ld);
      chk("dec_imm", dec_imm, m.imm);
      chk("dec_op1", dec_op1, m.op1);
      chk("dec_op2", dec_op2, m.op2);
      chk("dec_illegal", dec_illegal, m.ill);
    end
  endtask

  // One cycle: drive, check combinational outputs, clock, check registers.
  task automatic step(input logic [31:0] i, input logic [31:0] p, input logic v,
                      input logic f, input logic e, output logic took);
    logic u1, u2, hz, st;
    mstate_t n;
    instr = i; PC = p; pipeline_valid = v; flush = f; exe_stall = e;
    #1;
    u1 = !(i[6:0] inside {LUI, AUIPC, JAL});
    u2 = i[6:0] inside {BR, ST, OP};
    hz = v && m.v && m.ld && (m.rd != 0) &&
         (((m.rd == i[19:15]) && u1) || ((m.rd == i[24:20]) && u2));
    st = !f && (e || hz);
    chk("stall", stall, st);
    chk("rs1_addr", rs1_addr, i[19:15]);
    chk("rs2_addr", rs2_addr, i[24:20]);
    n = m;
    if (f)       n.v = 1'b0;
    else if (e)  n = m;
    else if (hz) n.v = 1'b0;
    else if (v)  n = cap(i, p);
    else         n.v = 1'b0;
    took = v && !st;
    @(posedge clk);
    #1;
    m = n;
    cmp_outputs();
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0: r[6:0] = LUI;   1: r[6:0] = AUIPC; 2: r[6:0] = JAL;  3: r[6:0] = JALR;
      4: r[6:0] = BR;    5: r[6:0] = LD;    6: r[6:0] = ST;   7: r[6:0] = OPI;
      8: r[6:0] = OP;    9: r[6:0] = LD;    10: r[6:0] = 7'h7F;
      default: ;  // arbitrary opcode, usually illegal
    endcase
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  localparam logic [31:0] ADDI = 32'h00A00093;  // addi x1,x0,10
  localparam logic [31:0] LW   = 32'h00012283;  // lw   x5,0(x2)
  localparam logic [31:0] ADD  = 32'h00128333;  // add  x6,x5,x1

  initial begin
    logic        took;
    logic [31:0] cur, pc;
    for (int k = 0; k < 32; k++) regs[k] = $urandom;
    m_clear();
    reset = 1'b0; instr = '0; PC = '0; pipeline_valid = 1'b0;
    flush = 1'b0; exe_stall = 1'b0;
    #12;
    chk("rst_valid", dec_valid, 1'b0);
    chk("rst_imm", dec_imm, 32'h0);
    chk("rst_PC", dec_PC, 32'h0);
    chk("rst_illegal", dec_illegal, 1'b0);
    reset = 1'b1;

    // addi capture
    step(ADDI, 32'h40, 1, 0, 0, took);
    chk("addi_valid", dec_valid, 1'b1);
    chk("addi_rd", dec_rd, 5'd1);
    chk("addi_imm", dec_imm, 32'd10);
    chk("addi_wr", dec_rd_wr_en, 1'b1);
    chk("addi_PC", dec_PC, 32'h40);

    // load-use: exactly one bubble
    step(LW, 32'h44, 1, 0, 0, took);
    step(ADD, 32'h48, 1, 0, 0, took);
    chk("lu_bubble", dec_valid, 1'b0);
    chk("lu_took1", took, 1'b0);
    step(ADD, 32'h48, 1, 0, 0, took);
    chk("lu_issue", dec_valid, 1'b1);
    chk("lu_took2", took, 1'b1);
    chk("lu_opcode", dec_opcode, 7'h33);

    // branch immediate and illegal opcode
    step(32'hFE000EE3, 32'h4C, 1, 0, 0, took);
    chk("br_imm", dec_imm, 32'hFFFFFFFC);
    chk("br_wr", dec_rd_wr_en, 1'b0);
    step(32'h0000007F, 32'h50, 1, 0, 0, took);
    chk("ill_flag", dec_illegal, 1'b1);
    chk("ill_valid", dec_valid, 1'b1);
    chk("ill_wr", dec_rd_wr_en, 1'b0);

    // exe_stall for three cycles, then a single capture
    step(ADDI, 32'h54, 1, 0, 0, took);
    for (int k = 0; k < 3; k++) begin
      step(LW, 32'h58, 1, 0, 1, took);
      chk("es_hold_PC", dec_PC, 32'h54);
    end
    step(LW, 32'h58, 1, 0, 0, took);
    chk("es_cap_PC", dec_PC, 32'h58);

    // flush beats exe_stall and a live hazard
    step(ADD, 32'h5C, 1, 1, 1, took);
    chk("fl_valid", dec_valid, 1'b0);

    // asynchronous reset between edges
    step(ADDI, 32'h60, 1, 0, 0, took);
    #3 reset = 1'b0;
    #1;
    chk("ar_valid", dec_valid, 1'b0);
    chk("ar_PC", dec_PC, 32'h0);
    chk("ar_imm", dec_imm, 32'h0);
    chk("ar_op1", dec_op1, 32'h0);
    chk("ar_rd", dec_rd, 5'h0);
    m_clear();
    #1 reset = 1'b1;

    // randomized traffic; fetch holds its instr until consumed
    cur = rnd_instr();
    pc  = 32'h100;
    for (int c = 0; c < 1500; c++) begin
      logic v, f, e;
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 6) == 0);
      step(cur, pc, v, f, e, took);
      if (took || f) begin
        cur = rnd_instr();
        pc  = pc + 4;
      end
      if ($urandom_range(0, 99) == 0) regs[$urandom_range(0, 3)] = $urandom;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the PC width.
REQ-002 SHALL have parameter INSTR_W, default 32, the instruction width (RV32I encoding).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port instr  input  INSTR_W  instruction from fetch.
REQ-006 SHALL have port PC  input  ADDR_W  address of instr.
REQ-007 SHALL have port pipeline_valid  input  1  instr/PC valid this cycle.
REQ-008 SHALL have port stall  output  1  tells fetch to hold PC and instr.
REQ-009 SHALL have port flush  input  1  redirect from execute; kill decode contents.
REQ-010 SHALL have port exe_stall  input  1  execute cannot accept this cycle.
REQ-011 SHALL have ports rs1_addr and rs2_addr  output  5 each  combinational regfile read addresses.
REQ-012 SHALL have ports rs1_data and rs2_data  input  32 each  combinational regfile read data.
REQ-013 SHALL have registered outputs: dec_valid 1, dec_PC ADDR_W, dec_opcode 7, dec_funct3 3, dec_funct7_b5 1, dec_rd 5, dec_rd_wr_en 1, dec_is_load 1, dec_imm 32, dec_op1 32, dec_op2 32, dec_illegal 1.

Function
REQ-014 SHALL decode combinationally from instr: rs1_addr=instr[19:15], rs2_addr=instr[24:20], rd=instr[11:7], regardless of pipeline_valid.
REQ-015 SHALL generate dec_imm sign-extended from instr[31]: I (LOAD, OP-IMM, JALR), S (STORE), B (BRANCH, bit0=0), U (LUI, AUIPC, low 12 bits 0), J (JAL, bit0=0); 0 for R-type.
REQ-016 SHALL set dec_op1=rs1_data and dec_op2=rs2_data at capture.
REQ-017 SHALL flag dec_illegal=1 for opcodes outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP} or instr[1:0]!=2'b11; illegal instrs still pass with dec_valid=1, dec_rd_wr_en=0.
REQ-018 SHALL set dec_rd_wr_en=1 only for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP with rd!=0.
REQ-019 SHALL define hazard = pipeline_valid & dec_valid & dec_is_load & (dec_rd!=0) & ((dec_rd==rs1_addr & instr uses rs1) | (dec_rd==rs2_addr & instr uses rs2)); rs1 unused by LUI/AUIPC/JAL; rs2 used only by BRANCH/STORE/OP.
REQ-020 SHALL drive stall = ~flush & (exe_stall | hazard), combinational.
REQ-021 SHALL, on posedge with flush=1, clear dec_valid to 0; flush wins over exe_stall and hazard.
REQ-022 SHALL, with flush=0 and exe_stall=1, hold all dec_* outputs unchanged.
REQ-023 SHALL, with flush=0, exe_stall=0, hazard=1, load a bubble: dec_valid=0, other dec_* unchanged; hazard then drops (dec_valid=0) and the held instr is accepted next cycle (exactly one bubble).
REQ-024 SHALL, with flush=0, exe_stall=0, hazard=0, pipeline_valid=1, capture decoded instr and PC with dec_valid=1 (1-cycle latency).
REQ-025 SHALL, with flush=0, exe_stall=0, hazard=0, pipeline_valid=0, set dec_valid=0.
REQ-026 SHALL never capture the same instr twice: an instr is consumed only on a posedge where pipeline_valid=1 and stall=0.

Reset
REQ-027 SHALL, while reset=0, asynchronously force every registered output to 0 (dec_valid=0, dec_illegal=0, dec_imm=0, dec_PC=0).
REQ-028 SHALL resume normal capture on the first posedge after reset deasserts; an instr in flight at reset assertion is discarded.

Verification
REQ-029 SHALL cover: instr=32'h00A00093 (addi x1,x0,10), PC=0x40, valid -> next cycle dec_valid=1, dec_rd=1, dec_imm=10, dec_rd_wr_en=1, dec_PC=0x40.
REQ-030 SHALL cover: lw x5,0(x2) then add x6,x5,x1 back-to-back -> stall=1 one cycle, one dec_valid=0 bubble, then add issues with dec_valid=1.
REQ-031 SHALL cover: BRANCH instr 32'hFE000EE3 -> dec_imm=0xFFFFFFFC, dec_rd_wr_en=0; instr 32'h0000007F -> dec_illegal=1, dec_valid=1.
REQ-032 SHALL cover: exe_stall=1 for 3 cycles with valid input -> stall=1, dec_* held constant 3 cycles, then single capture.
REQ-033 SHALL cover: flush=1 together with exe_stall=1 and hazard -> stall=0, dec_valid=0 next cycle.
REQ-034 SHALL cover: reset driven low between clock edges while dec_valid=1 -> all outputs 0 immediately, before next posedge.
